// File: rtl/frame_buffer_writer.sv
// Camera pixel stream to SDRAM writer: FIFO buffering, frame arming and per-pixel addressing.
// Optional FBW_DOUBLE_BUFFER_EN adds a ping-pong write bank and the bank_o output.
module frame_buffer_writer #(
  parameter int ADDR_W       = 24,
  parameter int FRAME_PIXELS = 76800,
  parameter int BASE_ADDR    = 0,
  parameter int FIFO_AW      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vsync_i,
  input  logic              pixelReady_i,
  input  logic [15:0]       pixel_i,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       data_o,
  input  logic              done_i,
  output logic              frameDone_o,
  output logic              overflow_o
`ifdef FBW_DOUBLE_BUFFER_EN
  ,
  output logic              bank_o
`endif
);

  localparam int IDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FRAME_N  = CNT_W'(FRAME_PIXELS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                  r_state;
  logic                    r_vsync_d;
  logic                    r_armed;
  logic [CNT_W-1:0]        r_in_count;
  logic [CNT_W-1:0]        r_wr_count;
  logic [FIFO_AW:0]        r_wptr;
  logic [FIFO_AW:0]        r_rptr;
  logic [IDX_W-1:0]        r_cur_idx;
  logic [16+IDX_W-1:0]     r_mem [DEPTH];

  logic                    w_frame_start;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_push_ok;
  logic                    w_push;
  logic                    w_pop;
  logic [16+IDX_W-1:0]     w_rd_entry;
  logic [ADDR_W-1:0]       w_issue_addr;

  assign w_frame_start = vsync_i & ~r_vsync_d;
  assign w_empty       = (r_wptr == r_rptr);
  assign w_full        = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                         (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_push_ok     = pixelReady_i & r_armed & ~w_frame_start & (r_in_count < FRAME_N);
  assign w_push        = w_push_ok & ~w_full;
  assign w_pop         = (r_state == S_IDLE) & ~w_empty & ~w_frame_start;
  assign w_rd_entry    = r_mem[r_rptr[FIFO_AW-1:0]];

`ifdef FBW_DOUBLE_BUFFER_EN
  logic r_wb;
  logic r_cur_bank;
  assign w_issue_addr = BASE_A + (r_wb ? ADDR_W'(FRAME_PIXELS) : '0) +
                        ADDR_W'(w_rd_entry[16 +: IDX_W]);
`else
  assign w_issue_addr = BASE_A + ADDR_W'(w_rd_entry[16 +: IDX_W]);
`endif

  // Input side: frame tracking, pixel counting and FIFO write pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vsync_d  <= 1'b0;
      r_armed    <= 1'b0;
      r_in_count <= '0;
      r_wptr     <= '0;
      overflow_o <= 1'b0;
`ifdef FBW_DOUBLE_BUFFER_EN
      r_wb       <= 1'b0;
`endif
    end else begin
      r_vsync_d <= vsync_i;
      if (w_frame_start) begin
        r_armed    <= 1'b1;
        r_in_count <= '0;
        r_wptr     <= '0;
        overflow_o <= 1'b0;
`ifdef FBW_DOUBLE_BUFFER_EN
        r_wb       <= ~r_wb;
`endif
      end else if (w_push_ok) begin
        r_in_count <= r_in_count + CNT_W'(1);
        if (w_full) overflow_o <= 1'b1;
        else        r_wptr     <= r_wptr + (FIFO_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {r_in_count[IDX_W-1:0], pixel_i};
  end

  // Output side: pop one entry, hold the request until the controller accepts it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_rptr      <= '0;
      r_wr_count  <= '0;
      r_cur_idx   <= '0;
      wr_o        <= 1'b0;
      addr_o      <= BASE_A;
      data_o      <= 16'h0000;
      frameDone_o <= 1'b0;
`ifdef FBW_DOUBLE_BUFFER_EN
      r_cur_bank  <= 1'b0;
      bank_o      <= 1'b0;
`endif
    end else begin
      frameDone_o <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_pop) begin
          r_rptr    <= r_rptr + (FIFO_AW+1)'(1);
          data_o    <= w_rd_entry[15:0];
          addr_o    <= w_issue_addr;
          r_cur_idx <= w_rd_entry[16 +: IDX_W];
          wr_o      <= 1'b1;
          r_state   <= S_WRITE;
`ifdef FBW_DOUBLE_BUFFER_EN
          r_cur_bank <= r_wb;
`endif
        end
      end else if (done_i) begin
        wr_o       <= 1'b0;
        r_wr_count <= r_wr_count + CNT_W'(1);
        r_state    <= S_IDLE;
        if (r_cur_idx == LAST_IDX) begin
          frameDone_o <= 1'b1;
`ifdef FBW_DOUBLE_BUFFER_EN
          bank_o      <= r_cur_bank;
`endif
        end
      end
      // A write already in flight finishes untouched; only queued pixels are flushed.
      if (w_frame_start) begin
        r_rptr     <= '0;
        r_wr_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: vector table, corner sequences, random stimulus
// checked against a queue-based reference model.
module tb_frame_buffer_writer;
  localparam int AW    = 24;
  localparam int N     = 8;
  localparam int BASE  = 'h100;
  localparam int FAW   = 2;
  localparam int DEPTH = 4;
`ifdef FBW_DOUBLE_BUFFER_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int F1 = BASE + (DB_EN ? N : 0);

  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, pr = 1'b0, done = 1'b0;
  logic [15:0] px = 16'h0;
  logic wr, fd, ovf;
  logic [AW-1:0] addr;
  logic [15:0] data;
`ifdef FBW_DOUBLE_BUFFER_EN
  logic bank;
`endif

  always #5 clk = ~clk;

  frame_buffer_writer #(.ADDR_W(AW), .FRAME_PIXELS(N), .BASE_ADDR(BASE), .FIFO_AW(FAW)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .vsync_i(vsync), .pixelReady_i(pr), .pixel_i(px),
    .wr_o(wr), .addr_o(addr), .data_o(data), .done_i(done),
    .frameDone_o(fd), .overflow_o(ovf)
`ifdef FBW_DOUBLE_BUFFER_EN
    , .bank_o(bank)
`endif
  );

  int n_chk = 0, n_err = 0;
  int n_wr_rise = 0, n_fd = 0;
  logic prev_wr = 1'b0;

  // Reference model: FIFO as a queue of pending writes, one outstanding request at a time.
  bit m_armed, m_vprev, m_busy, m_ovf, m_fd, m_wb, m_bank, m_cur_bank;
  int m_cnt, m_addr, m_data, m_idx;
  int qa[$], qd[$], qi[$], qb[$];

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_vprev = 0; m_busy = 0; m_ovf = 0; m_fd = 0; m_wb = 0; m_bank = 0;
    m_cur_bank = 0; m_cnt = 0; m_addr = BASE; m_data = 0; m_idx = 0;
    qa.delete(); qd.delete(); qi.delete(); qb.delete();
  endtask

  function automatic int cur_base();
    return BASE + (m_wb ? N : 0);
  endfunction

  task automatic model_edge(bit vs, bit p, logic [15:0] pix, bit dn);
    bit fs;
    int sz;
    fs = vs && !m_vprev;
    m_vprev = vs;
    sz = qa.size();
    m_fd = 0;
    if (m_busy) begin
      if (dn) begin
        m_busy = 0;
        if (m_idx == N - 1) begin
          m_fd = 1;
          m_bank = m_cur_bank;
        end
      end
    end else if (!fs && sz > 0) begin
      m_addr = qa.pop_front(); m_data = qd.pop_front();
      m_idx = qi.pop_front(); m_cur_bank = qb.pop_front();
      m_busy = 1;
    end
    if (fs) begin
      m_armed = 1; m_cnt = 0; m_ovf = 0;
      qa.delete(); qd.delete(); qi.delete(); qb.delete();
      if (DB_EN) m_wb = !m_wb;
    end else if (p && m_armed && m_cnt < N) begin
      if (sz == DEPTH) m_ovf = 1;
      else begin
        qa.push_back(cur_base() + m_cnt); qd.push_back(int'(pix));
        qi.push_back(m_cnt); qb.push_back(int'(m_wb));
      end
      m_cnt++;
    end
  endtask

  task automatic cycle(bit vs, bit p, logic [15:0] pix, bit dn);
    vsync = vs; pr = p; px = pix; done = dn;
    @(posedge clk);
    model_edge(vs, p, pix, dn);
    #1;
    if (wr && !prev_wr) n_wr_rise++;
    prev_wr = wr;
    if (fd) n_fd++;
    chk("m_wr", wr, m_busy);
    chk("m_addr", addr, m_addr);
    chk("m_data", data, m_data);
    chk("m_frameDone", fd, m_fd);
    chk("m_overflow", ovf, m_ovf);
`ifdef FBW_DOUBLE_BUFFER_EN
    chk("m_bank", bank, m_bank);
`endif
  endtask

  typedef struct {
    bit vs; bit pr; logic [15:0] px; bit dn;
    bit e_wr; int e_addr; logic [15:0] e_data; bit e_fd; bit e_ovf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit vs, bit p, logic [15:0] pix, bit dn,
                              bit ew, int ea, logic [15:0] ed, bit ef, bit eo);
    vec_t v;
    v.vs = vs; v.pr = p; v.px = pix; v.dn = dn;
    v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_fd = ef; v.e_ovf = eo;
    return v;
  endfunction

  initial begin
    int w0, f0, a0;
    bit vs_r;

    // Pixels before the first VSYNC rise are skipped; then one complete frame.
    tbl.push_back(mk(0, 1, 16'hA001, 0, 0, BASE, 16'h0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, BASE, 16'h0, 0, 0));
    tbl.push_back(mk(0, 1, 16'hA002, 0, 0, BASE, 16'h0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0,    0, 0, BASE, 16'h0, 0, 0));
    tbl.push_back(mk(1, 1, 16'hB000, 0, 0, BASE, 16'h0, 0, 0));
    for (int k = 0; k < N; k++) begin
      tbl.push_back(mk(1, 0, 16'h0, 0, 1, F1 + k, 16'hB000 + 16'(k), 0, 0));
      tbl.push_back(mk(1, (k < N - 1), 16'hB001 + 16'(k), 1,
                       0, F1 + k, 16'hB000 + 16'(k), (k == N - 1), 0));
    end
    tbl.push_back(mk(1, 1, 16'hC000, 0, 0, F1 + N - 1, 16'hB007, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0,    1, 0, F1 + N - 1, 16'hB007, 0, 0));

    model_reset();
    #22 rst_n = 1'b1;
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, BASE);
    chk("rst_data", data, 0);
    chk("rst_frameDone", fd, 0);
    chk("rst_overflow", ovf, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].vs, tbl[i].pr, tbl[i].px, tbl[i].dn);
      chk("tbl_wr", wr, tbl[i].e_wr);
      chk("tbl_addr", addr, tbl[i].e_addr);
      chk("tbl_data", data, tbl[i].e_data);
      chk("tbl_frameDone", fd, tbl[i].e_fd);
      chk("tbl_overflow", ovf, tbl[i].e_ovf);
    end

    // done held off: FIFO fills, extra pixel dropped, addresses stay index-correct.
    cycle(0, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    w0 = n_wr_rise; f0 = n_fd;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 16'hD000 + 16'(i), 0);
      cycle(1, 0, 16'h0, 0);
      chk("hold_wr", wr, 1);
      chk("hold_addr", addr, cur_base());
    end
    for (int i = 0; i < 8; i++) cycle(1, 0, 16'h0, 0);
    chk("hold_addr_end", addr, cur_base());
    chk("ovf_set", ovf, 1);
    for (int i = 0; i < 12; i++) cycle(1, 0, 16'h0, wr);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 16'hD006 + 16'(i), wr);
      cycle(1, 0, 16'h0, wr);
    end
    for (int i = 0; i < 8; i++) cycle(1, 0, 16'h0, wr);
    chk("ovf_writes", n_wr_rise - w0, 7);
    chk("ovf_frameDone", n_fd - f0, 1);
    chk("ovf_last_addr", addr, cur_base() + N - 1);
    cycle(0, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("ovf_clear", ovf, 0);

    // Frame start while a write waits on done.
    cycle(1, 1, 16'hF000, 0);
    cycle(1, 1, 16'hF001, 0);
    a0 = cur_base();
    cycle(0, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("fs_inflight_wr", wr, 1);
    cycle(1, 0, 16'h0, 1);
    chk("fs_old_addr", addr, a0);
    chk("fs_done_wr", wr, 0);
    cycle(1, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("flush_no_wr", wr, 0);
    cycle(1, 1, 16'hF100, 0);
    cycle(1, 0, 16'h0, 0);
    chk("restart_addr", addr, cur_base());
    chk("restart_data", data, 16'hF100);
    cycle(1, 0, 16'h0, 1);

    // Asynchronous reset while a request is pending.
    cycle(1, 1, 16'h1234, 0);
    cycle(1, 0, 16'h0, 0);
    chk("pre_rst_wr", wr, 1);
    #2 rst_n = 1'b0;
    vsync = 0; pr = 0; done = 0;
    #1;
    chk("async_rst_wr", wr, 0);
    chk("async_rst_addr", addr, BASE);
    chk("async_rst_data", data, 0);
    chk("async_rst_overflow", ovf, 0);
    model_reset();
    prev_wr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 16'h5550 + 16'(i), 0);
      cycle(0, 0, 16'h0, 0);
    end
    chk("unarmed_wr", n_wr_rise, n_wr_rise);
    chk("unarmed_no_wr", wr, 0);

    // Random traffic: pixels at most every other cycle, random done latency.
    vs_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) vs_r = !vs_r;
      cycle(vs_r, (c % 2 == 0) && ($urandom_range(0, 3) != 0), 16'($urandom),
            wr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
